// File: rtl/ctrl_arb_pkg.sv
// Shared types and sizing for the write-enable demux arbiter.
// The optional grant timeout (macro ARB_TIMEOUT_EN) uses HOLD_MAX and HOLD_W.
package ctrl_arb_pkg;

    localparam int NUM_REQ  = 8;
    localparam int SEL_W    = $clog2(NUM_REQ);
    localparam int HOLD_MAX = 15;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
    typedef logic [SEL_W-1:0] arb_sel_t;

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input arb_sel_t s);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_write_arbiter_if.sv
// Request/grant bundle between the requesting units, the arbiter and the demux.
// Handshake: a requester raises req and holds it for its whole use of the line; it owns the line while its gnt bit is high, and releases it by dropping req.
interface demux_write_arbiter_if;
    import ctrl_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    arb_sel_t           sel;
    logic               wr_en;
    logic               busy;
    logic               timeout;
    arb_state_t         state;

    modport master (output req, input gnt, sel, wr_en, busy, timeout, state);
    modport slave  (input req, output gnt, sel, wr_en, busy, timeout, state);
endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req_i at or after start_i, wrapping to 0.
module rr_pick
    import ctrl_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  arb_sel_t           start_i,
    output logic               valid_o,
    output arb_sel_t           winner_o
);

    arb_sel_t idx;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = arb_sel_t'((int'(start_i) + i) % NUM_REQ);
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/demux_write_arbiter.sv
// Round-robin owner of the shared write-enable line feeding the 1-to-NUM_REQ demux.
// Define ARB_TIMEOUT_EN to revoke grants after HOLD_MAX cycles and mask the owner until it drops req.
module demux_write_arbiter
    import ctrl_arb_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    demux_write_arbiter_if.slave       bus
);

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    arb_sel_t           sel_q;
    arb_sel_t           last_q;
    logic               wr_en_q;
    logic               busy_q;
    logic [NUM_REQ-1:0] eligible;
    arb_sel_t           start;
    logic               pick_valid;
    arb_sel_t           pick_idx;

`ifdef ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0] mask_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               timeout_q;

    assign eligible    = bus.req & ~mask_q;
    assign bus.timeout = timeout_q;
`else
    assign eligible    = bus.req;
    assign bus.timeout = 1'b0;
`endif

    assign start = (last_q == arb_sel_t'(NUM_REQ - 1)) ? '0 : last_q + 1'b1;

    rr_pick u_pick (
        .req_i    (eligible),
        .start_i  (start),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    // sel_q doubles as the owner index; it is only meaningful while in GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= arb_sel_t'(NUM_REQ - 1);
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            mask_q    <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
            mask_q    <= mask_q & bus.req;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= GRANT;
                        gnt_q   <= sel_to_onehot(pick_idx);
                        sel_q   <= pick_idx;
                        wr_en_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!bus.req[sel_q]) begin
                        state_q <= RELEASE;
                        gnt_q   <= '0;
                        wr_en_q <= 1'b0;
                        last_q  <= sel_q;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
                        state_q   <= RELEASE;
                        gnt_q     <= '0;
                        wr_en_q   <= 1'b0;
                        last_q    <= sel_q;
                        timeout_q <= 1'b1;
                        mask_q    <= (mask_q & bus.req) | sel_to_onehot(sel_q);
                    end else begin
                        hold_q <= hold_q + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.wr_en = wr_en_q;
    assign bus.busy  = busy_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_demux_write_arbiter.sv
// Directed bench for demux_write_arbiter: cycle table plus hand sequences for hold limit and async reset.
module tb_demux_write_arbiter;
    import ctrl_arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    demux_write_arbiter_if bus ();

    demux_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       wr_en;
        logic       busy;
    } vec_t;

    vec_t tbl [28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                             input logic w, input logic b, input logic t);
        check({tag, " gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, " sel"}, 32'(bus.sel), 32'(s));
        check({tag, " wr_en"}, 32'(bus.wr_en), 32'(w));
        check({tag, " busy"}, 32'(bus.busy), 32'(b));
        check({tag, " timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    initial begin
        logic [7:0] eg;
        logic       et;
        logic       eb;
        n_vec = 0;
        n_err = 0;

        // reset / grant 0 / single req 4 / wrap 7->0 / late req ignored
        tbl[0]  = '{8'hFF, 8'h01, 3'd0, 1'b1, 1'b1};
        tbl[1]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[2]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b1};
        tbl[4]  = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b1};
        tbl[5]  = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b1};
        tbl[6]  = '{8'h10, 8'h10, 3'd4, 1'b1, 1'b1};
        tbl[7]  = '{8'h00, 8'h00, 3'd4, 1'b0, 1'b1};
        tbl[8]  = '{8'h00, 8'h00, 3'd4, 1'b0, 1'b0};
        tbl[9]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
        tbl[10] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[11] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b1};
        tbl[13] = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b1};
        tbl[14] = '{8'h01, 8'h00, 3'd7, 1'b0, 1'b1};
        tbl[15] = '{8'h01, 8'h00, 3'd7, 1'b0, 1'b0};
        tbl[16] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
        tbl[17] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[18] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[19] = '{8'h20, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[20] = '{8'h24, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[21] = '{8'h20, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[22] = '{8'h24, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[23] = '{8'h04, 8'h00, 3'd5, 1'b0, 1'b1};
        tbl[24] = '{8'h04, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[25] = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
        tbl[26] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b1};
        tbl[27] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};

        // Reset held with every requester asking: nothing may be granted.
        rst     = 1'b1;
        bus.req = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            apply(tbl[i].req);
            check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].wr_en, tbl[i].busy, 1'b0);
        end

        // Requester 3 holds req for 20 cycles; the hold limit revokes at cycle 16 when enabled.
        for (int k = 1; k <= 20; k++) begin
            eg = (TO_EN && k >= 16) ? 8'h00 : 8'h08;
            et = (TO_EN && k == 16);
            eb = !(TO_EN && k >= 17);
            apply(8'h08);
            check_all($sformatf("hold%0d", k), eg, 3'd3, !(TO_EN && k >= 16), eb, et);
        end
        apply(8'h00);
        check_all("hold_drop", 8'h00, 3'd3, 1'b0, !TO_EN, 1'b0);
        apply(8'h00);
        check_all("hold_idle", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);
        apply(8'h08);
        check_all("regrant3", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        apply(8'h00);
        apply(8'h00);
        check_all("regrant3_done", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);

        // Owner 6 interrupted by an asynchronous reset between clock edges.
        apply(8'h40);
        check_all("own6", 8'h40, 3'd6, 1'b1, 1'b1, 1'b0);
        bus.req = 8'h41;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(8'h41);
        check_all("post_rst", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
